// File: rtl/irda_fir_lppm_encoder_pkg.sv
// Shared definitions for the FIR L-PPM transmit path: default symbol size,
// serialiser state type and the framing chip constants used by the framer.
package irda_fir_lppm_encoder_pkg;

    // Default data bits per PPM symbol (2 -> 4PPM).
    localparam int unsigned IRDA_PPM_SYM_BITS = 2;
    localparam int unsigned IRDA_PPM_CHIPS    = 1 << IRDA_PPM_SYM_BITS;

    // FIR framing sequences for 4PPM, split into 4-chip raw words.
    // Word i occupies bits [4i+3:4i] and is sent first for i=0.
    // Within each word bit 0 is the first chip on the line.
    // Preamble "1000 0000 1010 1000".
    localparam logic [15:0] IRDA_FIR_PREAMBLE   = 16'h1501;
    // Start flag "0000 1100 0000 1100 0110 0000 0110 0000".
    localparam logic [31:0] IRDA_FIR_START_FLAG = 32'h0606_3030;
    // Stop flag "0000 1100 0000 1100 0110 0000 0000 0110".
    localparam logic [31:0] IRDA_FIR_STOP_FLAG  = 32'h6006_3030;

    typedef enum logic {
        SER_IDLE,
        SER_ACTIVE
    } ser_state_t;

endpackage

// File: rtl/irda_fir_lppm_encoder_fifo.sv
// Small synchronous chip-word FIFO with registered occupancy count.
module irda_fir_ppm_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       wb_rst_i,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/irda_fir_lppm_encoder.sv
// L-PPM chip encoder: assembles serial bits into one-hot symbols, accepts raw
// framing chip words, queues both and serialises one chip per chip_en strobe.
module irda_fir_lppm_encoder
    import irda_fir_lppm_encoder_pkg::*;
#(
    parameter int unsigned SYM_BITS = IRDA_PPM_SYM_BITS,
    parameter int unsigned DEPTH    = 2
) (
    input  logic                      clk,
    input  logic                      wb_rst_i,
    input  logic                      restart,
    input  logic                      chip_en,
    input  logic                      bit_valid,
    input  logic                      bit_data,
    output logic                      bit_ready,
    input  logic                      raw_valid,
    input  logic [(1<<SYM_BITS)-1:0]  raw_chips,
    output logic                      raw_ready,
    output logic                      ppm_o,
    output logic                      active,
    output logic                      underrun,
    output logic                      fifo_empty
);

    localparam int unsigned CHIPS = 1 << SYM_BITS;
    localparam int unsigned CW    = (SYM_BITS > 1) ? $clog2(SYM_BITS) : 1;
    localparam int unsigned CNTW  = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(SYM_BITS - 1);

    logic [CW-1:0]       bit_cnt;
    logic [SYM_BITS-1:0] sym;
    logic [SYM_BITS-1:0] sym_next;
    logic [CHIPS-1:0]    sym_word;

    logic                raw_fire;
    logic                bit_fire;
    logic                push;
    logic                pop;
    logic [CHIPS-1:0]    push_data;
    logic [CHIPS-1:0]    head;
    logic [CNTW-1:0]     count;
    logic                full;
    logic                empty;

    ser_state_t          state;
    logic [SYM_BITS-1:0] chip_cnt;
    logic [CHIPS-1:0]    cur;

    // Symbol value including the bit being accepted this cycle.
    always_comb begin
        sym_next           = sym;
        sym_next[bit_cnt]  = bit_data;
        sym_word           = CHIPS'(1) << sym_next;
    end

    // Raw words only enter on a symbol boundary and win over a first data bit;
    // readiness looks only at registered state, never at a same-cycle pop.
    assign bit_ready = !(raw_valid && (bit_cnt == '0)) && ((bit_cnt != LAST_BIT) || !full);
    assign raw_ready = (bit_cnt == '0) && !full;

    assign raw_fire  = raw_valid && raw_ready;
    assign bit_fire  = bit_valid && bit_ready;
    assign push      = !restart && (raw_fire || (bit_fire && (bit_cnt == LAST_BIT)));
    assign push_data = raw_fire ? raw_chips : sym_word;
    assign pop       = !restart && chip_en && (chip_cnt == '0) && !empty;

    // Bit assembler: collect SYM_BITS bits LSB first, wrap at the last one.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            bit_cnt <= '0;
            sym     <= '0;
        end else if (restart) begin
            bit_cnt <= '0;
            sym     <= '0;
        end else if (bit_fire) begin
            sym     <= sym_next;
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CW'(1);
        end
    end

    irda_fir_ppm_fifo #(
        .WIDTH (CHIPS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .wb_rst_i  (wb_rst_i),
        .clear     (restart),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Serialiser: one chip per strobe; an empty FIFO once running emits a
    // zero symbol so later symbols stay on the chip grid.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= SER_IDLE;
            chip_cnt <= '0;
            cur      <= '0;
            ppm_o    <= 1'b0;
            underrun <= 1'b0;
        end else if (restart) begin
            state    <= SER_IDLE;
            chip_cnt <= '0;
            cur      <= '0;
            ppm_o    <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (chip_en) begin
                if (chip_cnt == '0) begin
                    if (!empty) begin
                        cur      <= head;
                        ppm_o    <= head[0];
                        state    <= SER_ACTIVE;
                        chip_cnt <= SYM_BITS'(1);
                    end else if (state == SER_ACTIVE) begin
                        cur      <= '0;
                        ppm_o    <= 1'b0;
                        underrun <= 1'b1;
                        chip_cnt <= SYM_BITS'(1);
                    end
                end else begin
                    ppm_o    <= cur[chip_cnt];
                    chip_cnt <= chip_cnt + SYM_BITS'(1);
                end
            end
        end
    end

    assign active     = (state == SER_ACTIVE);
    assign fifo_empty = (count == '0) && (chip_cnt == '0);

endmodule

// File: tb/tb_irda_fir_lppm_encoder.sv
// Directed bench for the L-PPM encoder: 4PPM instance for the main paths and
// an 8PPM instance for the wider symbol and asynchronous reset.
module tb_irda_fir_lppm_encoder;

    logic clk;
    logic wb_rst_i;

    // 4PPM instance signals
    logic       restart, chip_en, bit_valid, bit_data, raw_valid;
    logic [3:0] raw_chips;
    logic       bit_ready, raw_ready, ppm_o, active, underrun, fifo_empty;

    // 8PPM instance signals
    logic       restart8, chip_en8, bit_valid8, bit_data8, raw_valid8;
    logic [7:0] raw_chips8;
    logic       bit_ready8, raw_ready8, ppm8, active8, underrun8, fifo_empty8;

    int total = 0;
    int bad   = 0;

    logic [31:0] seq;
    logic [31:0] useq;
    int          sidx;
    logic        feed_en;
    bit          bitq[$];

    irda_fir_lppm_encoder #(.SYM_BITS(2), .DEPTH(2)) dut4 (
        .clk        (clk),
        .wb_rst_i   (wb_rst_i),
        .restart    (restart),
        .chip_en    (chip_en),
        .bit_valid  (bit_valid),
        .bit_data   (bit_data),
        .bit_ready  (bit_ready),
        .raw_valid  (raw_valid),
        .raw_chips  (raw_chips),
        .raw_ready  (raw_ready),
        .ppm_o      (ppm_o),
        .active     (active),
        .underrun   (underrun),
        .fifo_empty (fifo_empty)
    );

    irda_fir_lppm_encoder #(.SYM_BITS(3), .DEPTH(2)) dut8 (
        .clk        (clk),
        .wb_rst_i   (wb_rst_i),
        .restart    (restart8),
        .chip_en    (chip_en8),
        .bit_valid  (bit_valid8),
        .bit_data   (bit_data8),
        .bit_ready  (bit_ready8),
        .raw_valid  (raw_valid8),
        .raw_chips  (raw_chips8),
        .raw_ready  (raw_ready8),
        .ppm_o      (ppm8),
        .active     (active8),
        .underrun   (underrun8),
        .fifo_empty (fifo_empty8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; optionally feeds queued bits through the handshake.
    task automatic tick();
        logic fire;
        if (feed_en) begin
            bit_valid = (bitq.size() > 0);
            if (bitq.size() > 0) bit_data = bitq[0];
        end
        #2;
        fire = bit_valid && bit_ready;
        @(posedge clk);
        #1;
        if (feed_en && fire) void'(bitq.pop_front());
        if (feed_en && bitq.size() == 0) bit_valid = 1'b0;
    endtask

    task automatic chip_step();
        chip_en = 1'b1;
        tick();
        seq[sidx]  = ppm_o;
        useq[sidx] = underrun;
        sidx++;
        chip_en = 1'b0;
        tick();
    endtask

    task automatic chip_step8();
        chip_en8 = 1'b1;
        tick();
        seq[sidx] = ppm8;
        sidx++;
        chip_en8 = 1'b0;
        tick();
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic clear_log();
        seq  = '0;
        useq = '0;
        sidx = 0;
    endtask

    initial begin
        wb_rst_i = 1'b1;
        restart = 0; chip_en = 0; bit_valid = 0; bit_data = 0; raw_valid = 0; raw_chips = '0;
        restart8 = 0; chip_en8 = 0; bit_valid8 = 0; bit_data8 = 0; raw_valid8 = 0; raw_chips8 = '0;
        feed_en = 1'b0;
        clear_log();

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_ppm", ppm_o, 0);
        chk("rst_active", active, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_fifo_empty", fifo_empty, 1);
        chk("rst_bit_ready", bit_ready, 1);
        chk("rst_raw_ready", raw_ready, 1);
        wb_rst_i = 1'b0;

        // Four symbols 0,1,2,3 -> chips 1000 0100 0010 0001
        feed_en = 1'b1;
        bitq = '{0, 0, 1, 0, 0, 1, 1, 1};
        repeat (3) tick();
        chk("t1_active_before", active, 0);
        clear_log();
        chip_step();
        chk("t1_active_first_chip", active, 1);
        repeat (15) chip_step();
        chk("t1_chips", seq[15:0], 16'h8421);
        chk("t1_no_underrun", useq[15:0], 16'h0000);
        feed_en = 1'b0;
        bit_valid = 1'b0;
        do_restart();

        // Raw word and first data bit together: raw wins
        raw_valid = 1'b1;
        raw_chips = 4'b0001;
        bit_valid = 1'b1;
        bit_data  = 1'b1;
        #1;
        chk("t2_raw_ready", raw_ready, 1);
        chk("t2_bit_blocked", bit_ready, 0);
        tick();
        raw_valid = 1'b0;
        tick();
        tick();
        bit_valid = 1'b0;
        clear_log();
        repeat (8) chip_step();
        chk("t2_chips", seq[7:0], 8'h81);
        chk("t2_no_underrun", useq[7:0], 8'h00);
        do_restart();

        // FIFO fill with chip_en stalled, then drain in order
        raw_valid = 1'b1;
        raw_chips = 4'b0010;
        tick();
        raw_chips = 4'b0100;
        tick();
        raw_valid = 1'b0;
        #1;
        chk("t3_raw_ready_full", raw_ready, 0);
        chk("t3_fifo_not_empty", fifo_empty, 0);
        bit_valid = 1'b1;
        bit_data  = 1'b1;
        tick();
        chk("t3_bit_ready_full", bit_ready, 0);
        chk("t3_raw_ready_mid", raw_ready, 0);
        tick();
        chk("t3_bit_ready_stall", bit_ready, 0);
        clear_log();
        chip_en = 1'b1;
        tick();
        seq[0] = ppm_o;
        chip_en = 1'b0;
        #1;
        chk("t3_bit_ready_after_pop", bit_ready, 1);
        tick();
        bit_valid = 1'b0;
        sidx = 1;
        repeat (11) chip_step();
        chk("t3_chips", seq[11:0], 12'h842);
        chk("t3_no_underrun", useq[11:0], 12'h000);
        do_restart();

        // Underrun then realigned restart of data
        feed_en = 1'b1;
        bitq = '{0, 1};
        repeat (3) tick();
        clear_log();
        repeat (5) chip_step();
        bitq = '{1, 1};
        repeat (7) chip_step();
        chk("t4_chips", seq[11:0], 12'h804);
        chk("t4_underrun", useq[11:0], 12'h010);
        chk("t4_active", active, 1);
        feed_en = 1'b0;
        bit_valid = 1'b0;
        do_restart();

        // restart mid-symbol with a word queued
        raw_valid = 1'b1;
        raw_chips = 4'b0010;
        tick();
        raw_chips = 4'b0100;
        tick();
        raw_valid = 1'b0;
        clear_log();
        repeat (2) chip_step();
        chk("t5_ppm_before", ppm_o, 1);
        restart = 1'b1;
        tick();
        chk("t5_ppm_cleared", ppm_o, 0);
        chk("t5_active_cleared", active, 0);
        chk("t5_fifo_empty", fifo_empty, 1);
        restart = 1'b0;
        bit_valid = 1'b1;
        bit_data  = 1'b0;
        tick();
        tick();
        bit_valid = 1'b0;
        clear_log();
        repeat (4) chip_step();
        chk("t5_fresh_chips", seq[3:0], 4'b0001);
        chk("t5_no_underrun", useq[3:0], 4'b0000);

        // 8PPM: value 5 -> 00000100
        bit_valid8 = 1'b1;
        bit_data8  = 1'b1;
        tick();
        bit_data8  = 1'b0;
        tick();
        bit_data8  = 1'b1;
        tick();
        bit_valid8 = 1'b0;
        clear_log();
        repeat (8) chip_step8();
        chk("t6_chips8", seq[7:0], 8'h20);
        chk("t6_active8", active8, 1);

        // 8PPM: value 1, async reset while its high chip is on the line
        bit_valid8 = 1'b1;
        bit_data8  = 1'b1;
        tick();
        bit_data8  = 1'b0;
        tick();
        tick();
        bit_valid8 = 1'b0;
        clear_log();
        repeat (2) chip_step8();
        chk("t6_ppm8_high", ppm8, 1);
        #2;
        wb_rst_i = 1'b1;
        #1;
        chk("t6_rst_ppm8", ppm8, 0);
        chk("t6_rst_active8", active8, 0);
        chk("t6_rst_underrun8", underrun8, 0);
        chk("t6_rst_fifo_empty8", fifo_empty8, 1);
        chk("t6_rst_ppm4", ppm_o, 0);
        #1;
        wb_rst_i = 1'b0;
        tick();
        chk("t6_idle_after_rst", active8, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
